fm_mean_mc: RTL and testbench
=============================

Name: fm_mean_mc

Overview:
- Multi-channel, fixed-point feature-map mean/mean-square engine.
- Each beat carries N signed lanes tagged with a channel ID. The block sums the lanes through a registered adder tree and accumulates per channel over a frame.
- At frame end it scales each channel sum by a reciprocal (1/H·W) and emits CH results in channel order under ready/valid backpressure.
- Sits after the feature-map stream, feeding normalisation/statistics consumers.

Parameters:
- BW, 16, input/output lane width, signed two's complement
- N, 8, lanes per beat, power of 2, ≥2; L = log2(N)
- CH, 4, channel accumulators, ≥1
- ACC_W, 48, accumulator width; ≥ 2*BW+L+frame-length bits
- RECIP_W, 16, reciprocal width, unsigned Q0.RECIP_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in  in  N*BW  lanes; lane k = in[k*BW +: BW]
- in_ch  in  max(1,clog2(CH))  channel ID of beat
- in_valid  in  1  beat valid
- in_last  in  1  last beat of frame
- in_ready  out  1  beat accepted when in_valid&&in_ready
- mode  in  1  0=mean, 1=mean of squares; sampled on first beat of frame
- recip  in  RECIP_W  scale factor; sampled on entry to EMIT
- out  out  BW  scaled result
- out_ch  out  max(1,clog2(CH))  channel of out
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_last  out  1  high with channel CH-1 result
- err  out  1  sticky: beat with in_ch ≥ CH dropped; cleared only by rst

Behaviour:
- Reset: state IDLE; all pipeline valids, accumulators, out, out_ch, out_valid, out_last, err = 0; in_ready = 1 from first cycle after reset.
- States and transitions:
  - IDLE: in_ready=1. First accepted beat clears all CH accumulators, latches mode, and goes to ACCUM. If that beat has in_last, go directly to DRAIN.
  - ACCUM: in_ready=1. The beat accepted with in_last goes to DRAIN.
  - DRAIN: in_ready=0. Wait exactly L+2 cycles so the pipeline empties into the accumulators, then go to EMIT.
  - EMIT: in_ready=0. Output channel 0..CH-1, one per out handshake; out_last=1 on CH-1. Handshake of CH-1 goes to IDLE.
- Pipeline:
  - Stage 0: per lane, sign-extend (mode 0) or square (mode 1) to 2*BW.
  - L registered tree levels, each adding 1 bit.
  - Accumulate into acc[ch] with sign extension to ACC_W, modular wrap.
  - Channel ID and valid travel with the data.
  - Latency from beat acceptance to accumulator update = L+2 cycles.
- Out-of-range channel: beat still handshakes but does not enter the pipeline; err set. If it carries in_last, the frame still closes.
- Scaling (loaded into output register):
  - p = acc*recip + 2^(RECIP_W-1); r = p >>> RECIP_W (arithmetic, round half up).
  - Saturate r to [-2^(BW-1), 2^(BW-1)-1].
- Output timing:
  - First out_valid appears L+4 cycles after last-beat acceptance (cycle t+7 for N=8).
  - After each handshake, the next channel loads the following cycle, so out_valid is low one cycle between results.
  - out, out_ch, out_last are held stable while out_valid && !out_ready.
- Channels with no beats in the frame output 0.
- rst mid-frame or mid-EMIT: immediate return to reset state; partial results discarded; no out_valid until a new frame completes.

Test Plan (N=8, BW=16, CH=4 unless stated):
- Mean: 2 beats, ch0, all lanes=100, mode 0, recip=0x1000 -> out ch0=100, ch1..3=0; out_last with ch3; first out_valid at t_last+7.
- Mean of squares: 1 beat, ch2, all lanes=-3, mode 1, recip=0x2000 -> ch2=9, others 0.
- Rounding: single lane=3, other lanes 0, recip=0x8000 -> 2; same with lane=-3 -> -1.
- Saturation: 16 beats ch1, all lanes=32767, recip=0xFFFF -> 32767; all lanes=-32768 -> -32768.
- Backpressure/interleave: beats alternating ch0/ch3 with values 10/20, 4 beats, recip=0x2000, out_ready low 5 cycles -> out held stable, in_ready=0 throughout EMIT; results ch0=20, ch3=40.
- Fault cases:
  - CH=3, beat with in_ch=3 -> err=1, accumulators unchanged.
  - rst asserted in DRAIN -> no out_valid, in_ready=1 next cycle, err=0.

Source files
------------

// File: rtl/fm_mean_mc_if.sv
// Stream interface for fm_mean_mc.
// Input side : in (N lanes of BW bits), in_ch, in_valid, in_last, in_ready, mode.
// Output side: out, out_ch, out_valid, out_ready, out_last.
// Side band  : recip (scale factor), err (sticky bad-channel flag).
// master = producer/consumer environment, slave = the engine.
interface fm_mean_mc_if #(
    parameter int BW      = 16,
    parameter int N       = 8,
    parameter int CH      = 4,
    parameter int RECIP_W = 16
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic [N*BW-1:0]    in;
    logic [CHW-1:0]     in_ch;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic               mode;
    logic [RECIP_W-1:0] recip;
    logic [BW-1:0]      out;
    logic [CHW-1:0]     out_ch;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               err;

    modport master (
        output in, in_ch, in_valid, in_last, mode, recip, out_ready,
        input  in_ready, out, out_ch, out_valid, out_last, err
    );

    modport slave (
        input  in, in_ch, in_valid, in_last, mode, recip, out_ready,
        output in_ready, out, out_ch, out_valid, out_last, err
    );
endinterface

// File: rtl/fm_mean_mc.sv
// Multi-channel feature-map mean / mean-of-squares engine.
// Each accepted beat of N signed lanes is reduced by a registered adder tree
// and accumulated into the accumulator of its channel. After the frame's last
// beat the pipeline drains, then every channel sum is scaled by recip
// (unsigned Q0.RECIP_W, round half up, saturated to BW bits) and emitted in
// channel order.
// Ports: clk, rst (synchronous, active high), bus (fm_mean_mc_if.slave).
module fm_mean_mc #(
    parameter int BW      = 16,
    parameter int N       = 8,
    parameter int CH      = 4,
    parameter int ACC_W   = 48,
    parameter int RECIP_W = 16
) (
    input logic          clk,
    input logic          rst,
    fm_mean_mc_if.slave  bus
);
    localparam int L   = $clog2(N);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    // Tree entries are all kept at the final tree width; a level only ever
    // needs one more bit than the previous, so the sums are identical.
    localparam int TW  = 2*BW + L;
    localparam int PW  = ACC_W + RECIP_W + 1;
    localparam int RW  = ACC_W + 1;
    localparam int DCW = $clog2(L + 3);
    localparam logic signed [PW-1:0] RND =
        {{(PW-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-BW+1){1'b1}}, {(BW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

    state_t                   state_r, state_s;
    logic [DCW-1:0]           drain_cnt_r;
    logic                     in_ready_r, mode_r, err_r;
    logic [RECIP_W-1:0]       recip_r;
    logic                     accept_s, ch_ok_s, mode_eff_s, out_hs_s;
    logic signed [TW-1:0]     lane0_s [0:N-1];
    logic signed [TW-1:0]     lvl_r   [0:L][0:N-1];
    logic                     vld_r   [0:L];
    logic [CHW-1:0]           ch_r    [0:L];
    logic signed [ACC_W-1:0]  acc_r   [0:CH-1];
    logic [CHW-1:0]           idx_r;
    logic signed [PW-1:0]     prod_s, prod_r;
    logic                     prod_vld_r;
    logic signed [RW-1:0]     r_s;
    logic [BW-1:0]            sat_s;
    logic [BW-1:0]            out_r;
    logic [CHW-1:0]           out_ch_r;
    logic                     out_valid_r, out_last_r;

    // Next-state logic and handshake decode.
    always_comb begin
        state_s  = state_r;
        accept_s = bus.in_valid && in_ready_r;
        out_hs_s = out_valid_r && bus.out_ready;
        ch_ok_s  = (int'(bus.in_ch) < CH);
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = bus.in_last ? DRAIN : ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && bus.in_last) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACCUM;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DCW'(L + 1)) begin
                    state_s = EMIT;
                end else begin
                    state_s = DRAIN;
                end
            end
            EMIT: begin
                if (out_hs_s && out_last_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = EMIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, drain counter, frame-level latches and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            drain_cnt_r <= {DCW{1'b0}};
            in_ready_r  <= 1'b1;
            mode_r      <= 1'b0;
            recip_r     <= {RECIP_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE) || (state_s == ACCUM);
            if (state_r == DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DCW'(1);
            end else begin
                drain_cnt_r <= {DCW{1'b0}};
            end
            if ((state_r == IDLE) && accept_s) begin
                mode_r <= bus.mode;
            end
            if ((state_r == DRAIN) && (state_s == EMIT)) begin
                recip_r <= bus.recip;
            end
            if (accept_s && !ch_ok_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Stage 0 lane conditioning; the first beat of a frame uses the live mode.
    always_comb begin
        mode_eff_s = (state_r == IDLE) ? bus.mode : mode_r;
        for (int k = 0; k < N; k++) begin
            lane0_s[k] = {{(TW-BW){bus.in[k*BW+BW-1]}}, bus.in[k*BW +: BW]};
            if (mode_eff_s) begin
                lane0_s[k] = lane0_s[k] * lane0_s[k];
            end else begin
                lane0_s[k] = lane0_s[k];
            end
        end
    end

    // Stage 0 register plus L registered adder-tree levels; channel and valid ride along.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j <= L; j++) begin
                vld_r[j] <= 1'b0;
            end
        end else begin
            vld_r[0] <= accept_s && ch_ok_s;
            ch_r[0]  <= bus.in_ch;
            for (int k = 0; k < N; k++) begin
                lvl_r[0][k] <= lane0_s[k];
            end
            for (int j = 0; j < L; j++) begin
                vld_r[j+1] <= vld_r[j];
                ch_r[j+1]  <= ch_r[j];
                for (int i = 0; i < N; i++) begin
                    if (i < (N >> (j + 1))) begin
                        lvl_r[j+1][i] <= lvl_r[j][2*i] + lvl_r[j][2*i+1];
                    end else begin
                        lvl_r[j+1][i] <= {TW{1'b0}};
                    end
                end
            end
        end
    end

    // Per-channel accumulators: cleared by the first beat of a frame, wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                acc_r[c] <= {ACC_W{1'b0}};
            end
        end else if ((state_r == IDLE) && accept_s) begin
            for (int c = 0; c < CH; c++) begin
                acc_r[c] <= {ACC_W{1'b0}};
            end
        end else if (vld_r[L]) begin
            acc_r[ch_r[L]] <= acc_r[ch_r[L]]
                            + {{(ACC_W-TW){lvl_r[L][0][TW-1]}}, lvl_r[L][0]};
        end
    end

    // Scaling: the product is prepared for the channel that will load next,
    // so a result can load the cycle after the previous handshake.
    always_comb begin
        int sel;
        sel = int'(idx_r) + (out_hs_s ? 1 : 0);
        if (sel >= CH) begin
            sel = 0;
        end else begin
            sel = sel;
        end
        prod_s = {{(PW-ACC_W){acc_r[sel][ACC_W-1]}}, acc_r[sel]}
               * {{(PW-RECIP_W){1'b0}}, recip_r} + RND;
        r_s = RW'(prod_r >>> RECIP_W);
        if (r_s > SAT_MAX) begin
            sat_s = SAT_MAX[BW-1:0];
        end else if (r_s < SAT_MIN) begin
            sat_s = SAT_MIN[BW-1:0];
        end else begin
            sat_s = r_s[BW-1:0];
        end
    end

    // Output register: loads only while empty, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= {CHW{1'b0}};
            prod_r      <= {PW{1'b0}};
            prod_vld_r  <= 1'b0;
            out_r       <= {BW{1'b0}};
            out_ch_r    <= {CHW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            prod_r     <= prod_s;
            prod_vld_r <= (state_r == EMIT);
            if (state_r != EMIT) begin
                idx_r       <= {CHW{1'b0}};
                out_valid_r <= 1'b0;
            end else if (out_hs_s) begin
                idx_r       <= idx_r + CHW'(1);
                out_valid_r <= 1'b0;
            end else if (!out_valid_r && prod_vld_r) begin
                out_r       <= sat_s;
                out_ch_r    <= idx_r;
                out_last_r  <= (int'(idx_r) == CH - 1);
                out_valid_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out       = out_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_fm_mean_mc.sv
// Scoreboard bench for fm_mean_mc: stimulus pushes expected results, monitors
// pop and compare on every output handshake.
module tb_fm_mean_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct { int ch; int val; bit last; } exp_t;
    exp_t q[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    fm_mean_mc_if #(.BW(16), .N(8), .CH(4), .RECIP_W(16)) bus ();
    fm_mean_mc_if #(.BW(16), .N(8), .CH(3), .RECIP_W(16)) bus3 ();

    fm_mean_mc #(.BW(16), .N(8), .CH(4), .ACC_W(48), .RECIP_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    fm_mean_mc #(.BW(16), .N(8), .CH(3), .ACC_W(48), .RECIP_W(16)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave));

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push4(input int v0, input int v1, input int v2, input int v3);
        q.push_back('{0, v0, 1'b0});
        q.push_back('{1, v1, 1'b0});
        q.push_back('{2, v2, 1'b0});
        q.push_back('{3, v3, 1'b1});
    endtask

    // Lane 0 carries v0, lanes 1..7 carry v_all.
    task automatic send_beat(input int ch, input int v_all, input int v0,
                             input bit last, input bit md);
        for (int k = 0; k < 8; k++) begin
            bus.in[k*16 +: 16] = (k == 0) ? 16'(v0) : 16'(v_all);
        end
        bus.in_ch    = 2'(ch);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.mode     = md;
        check("in_ready_accept", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the last beat was accepted.
    task automatic wait_results(input bit bp);
        int lat = 0;
        int b = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_valid_latency", lat, 7);
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                check("bp_valid", longint'(bus.out_valid), 1);
                check("bp_out_held", longint'($signed(bus.out)), 20);
                check("bp_ch_held", longint'(bus.out_ch), 0);
                check("bp_in_ready", longint'(bus.in_ready), 0);
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'b1;
        end
        while (q.size() > 0 && b < 200) begin
            check("in_ready_emit", longint'(bus.in_ready), 0);
            @(posedge clk);
            #1;
            b++;
        end
        check("results_drained", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor for the CH=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_val", longint'($signed(bus.out)), e.val);
                check("out_ch", longint'(bus.out_ch), e.ch);
                check("out_last", longint'(bus.out_last), longint'(e.last));
            end
        end
    end

    // Monitor for the CH=3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus3.out_valid && bus3.out_ready) begin
            if (q3.size() == 0) begin
                check("unexpected_out3", 1, 0);
            end else begin
                e = q3.pop_front();
                check("out3_val", longint'($signed(bus3.out)), e.val);
                check("out3_ch", longint'(bus3.out_ch), e.ch);
                check("out3_last", longint'(bus3.out_last), longint'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        bus.in = '0;  bus.in_ch = 2'd0;  bus.in_valid = 1'b0;  bus.in_last = 1'b0;
        bus.mode = 1'b0;  bus.recip = 16'h0000;  bus.out_ready = 1'b1;
        bus3.in = '0; bus3.in_ch = 2'd0; bus3.in_valid = 1'b0; bus3.in_last = 1'b0;
        bus3.mode = 1'b0; bus3.recip = 16'h2000; bus3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out", longint'(bus.out), 0);
        check("rst_out_ch", longint'(bus.out_ch), 0);
        check("rst_out_last", longint'(bus.out_last), 0);
        check("rst_err", longint'(bus.err), 0);

        // Mean: 2 beats of 8 x 100 on ch0, 1/16 scale.
        bus.recip = 16'h1000;
        push4(100, 0, 0, 0);
        send_beat(0, 100, 100, 1'b0, 1'b0);
        send_beat(0, 100, 100, 1'b1, 1'b0);
        wait_results(1'b0);

        // Mean of squares: one beat of -3 on ch2, 1/8 scale.
        bus.recip = 16'h2000;
        push4(0, 0, 9, 0);
        send_beat(2, -3, -3, 1'b1, 1'b1);
        wait_results(1'b0);

        // Rounding: 3 * 0.5 = 1.5 -> 2, -1.5 -> -1.
        bus.recip = 16'h8000;
        push4(2, 0, 0, 0);
        send_beat(0, 0, 3, 1'b1, 1'b0);
        wait_results(1'b0);
        push4(-1, 0, 0, 0);
        send_beat(0, 0, -3, 1'b1, 1'b0);
        wait_results(1'b0);

        // Saturation in both directions.
        bus.recip = 16'hFFFF;
        push4(0, 32767, 0, 0);
        for (int i = 0; i < 16; i++) send_beat(1, 32767, 32767, (i == 15), 1'b0);
        wait_results(1'b0);
        push4(0, -32768, 0, 0);
        for (int i = 0; i < 16; i++) send_beat(1, -32768, -32768, (i == 15), 1'b0);
        wait_results(1'b0);

        // Interleaved channels with output backpressure.
        bus.recip = 16'h2000;
        push4(20, 0, 0, 40);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat((i % 2 == 0) ? 0 : 3, (i % 2 == 0) ? 10 : 20,
                      (i % 2 == 0) ? 10 : 20, (i == 3), 1'b0);
        end
        wait_results(1'b1);

        // Reset while draining: no results, ready again immediately.
        send_beat(1, 50, 50, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("drain_rst_in_ready", longint'(bus.in_ready), 1);
        check("drain_rst_err", longint'(bus.err), 0);
        for (int i = 0; i < 20; i++) begin
            check("drain_rst_no_valid", longint'(bus.out_valid), 0);
            @(posedge clk);
            #1;
        end

        // A fresh frame after the reset works normally.
        bus.recip = 16'h1000;
        push4(0, 0, 0, 100);
        send_beat(3, 100, 100, 1'b0, 1'b0);
        send_beat(3, 100, 100, 1'b1, 1'b0);
        wait_results(1'b0);

        // CH=3 instance: channel 3 is out of range and must be dropped.
        q3.push_back('{0, 1, 1'b0});
        q3.push_back('{1, 0, 1'b0});
        q3.push_back('{2, 0, 1'b1});
        bus3.in = {8{16'd1}};
        bus3.in_ch = 2'd0;
        bus3.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("err3_before", longint'(bus3.err), 0);
        bus3.in = {8{16'd100}};
        bus3.in_ch = 2'd3;
        bus3.in_last = 1'b1;
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        bus3.in_last = 1'b0;
        check("err3_set", longint'(bus3.err), 1);
        b = 0;
        while (q3.size() > 0 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("results3_drained", q3.size(), 0);
        check("err3_sticky", longint'(bus3.err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
